// File: rtl/score_keeper.sv
// score_keeper: per-frame score accumulator downstream of jumplogic.
// Once per video frame, the scrolled pixels are added to a residue.
// A subtract loop then turns that residue into points, one point per cycle.
// The score is a saturating 6-digit BCD value, and a high score is also kept.
// Optional feature macro: SCORE_HISCORE_EN. When it is defined, the high-score
// register, the compare logic and new_high are built. When it is undefined,
// hiscore_bcd and new_high are tied to zero.
module score_keeper #(
    parameter int PIX_PER_POINT = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        refresh_en,
    input  logic [7:0]  displacement,
    input  logic        game_over,
    input  logic        new_game,
    output logic [23:0] score_bcd,
    output logic [23:0] hiscore_bcd,
    output logic        new_high,
    output logic        busy,
    output logic        over
);

    // PIX_PER_POINT is at most 255, so the residue never exceeds 254+255 = 509.
    localparam logic [8:0] PPP9 = 9'(PIX_PER_POINT);
    localparam logic [23:0] SCORE_MAX = 24'h999999;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        UPDATE = 2'd1,
        OVER   = 2'd2
    } state_t;

    state_t      state_r;
    logic        frame_prev_r;
    logic [8:0]  residue_r;
    logic [23:0] score_r;
    logic        busy_r;
    logic        over_r;

    logic        tick_s;
    logic        step_s;
    logic [23:0] score_inc_s;

    // Add one to a 6-digit BCD value, with the carry rippling through every digit.
    // The value stops at 999999.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == SCORE_MAX) begin
            r = v;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        carry       = 1'b1;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4];
                end
            end
        end
        return r;
    endfunction

    // Combinational helpers: frame edge detect, the subtract-loop condition and the next score.
    always_comb begin
        tick_s      = frame_clk & ~frame_prev_r;
        step_s      = (residue_r >= PPP9);
        score_inc_s = bcd_inc(score_r);
    end

`ifdef SCORE_HISCORE_EN
    logic [23:0] hiscore_r;
    logic        new_high_r;
    logic        higher_s;

    // An unsigned compare of valid BCD vectors matches the numeric order.
    always_comb begin
        higher_s = (score_r > hiscore_r);
    end
`endif

    // Main controller: frame sampling, residue and score update, and game-over handling.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r      <= PLAY;
            frame_prev_r <= 1'b0;
            residue_r    <= 9'd0;
            score_r      <= 24'd0;
            busy_r       <= 1'b0;
            over_r       <= 1'b0;
`ifdef SCORE_HISCORE_EN
            hiscore_r    <= 24'd0;
            new_high_r   <= 1'b0;
`endif
        end else begin
            frame_prev_r <= frame_clk;
            case (state_r)
                PLAY, UPDATE: begin
                    if (game_over) begin
                        // Game over beats a pending tick or update step; any unspent residue is dropped.
                        state_r   <= OVER;
                        residue_r <= 9'd0;
                        busy_r    <= 1'b0;
                        over_r    <= 1'b1;
`ifdef SCORE_HISCORE_EN
                        if (higher_s) begin
                            hiscore_r  <= score_r;
                            new_high_r <= 1'b1;
                        end else begin
                            new_high_r <= 1'b0;
                        end
`endif
                    end else if (state_r == PLAY) begin
                        if (tick_s && refresh_en) begin
                            residue_r <= residue_r + {1'b0, displacement};
                            state_r   <= UPDATE;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r   <= PLAY;
                        end
                    end else begin
                        // UPDATE: take one point per cycle. Once the score saturates, the
                        // residue still decrements and the increment is lost.
                        if (step_s) begin
                            residue_r <= residue_r - PPP9;
                            score_r   <= score_inc_s;
                        end else begin
                            state_r   <= PLAY;
                            busy_r    <= 1'b0;
                        end
                    end
                end
                OVER: begin
                    if (new_game && !game_over) begin
                        state_r    <= PLAY;
                        score_r    <= 24'd0;
                        residue_r  <= 9'd0;
                        over_r     <= 1'b0;
`ifdef SCORE_HISCORE_EN
                        new_high_r <= 1'b0;
`endif
                    end else begin
                        state_r    <= OVER;
                    end
                end
                default: begin
                    state_r   <= PLAY;
                    residue_r <= 9'd0;
                    busy_r    <= 1'b0;
                    over_r    <= 1'b0;
                end
            endcase
        end
    end

    assign score_bcd = score_r;
    assign busy      = busy_r;
    assign over      = over_r;

`ifdef SCORE_HISCORE_EN
    assign hiscore_bcd = hiscore_r;
    assign new_high    = new_high_r;
`else
    assign hiscore_bcd = 24'h000000;
    assign new_high    = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper.
// It drives two instances: one with PIX_PER_POINT=8 and one with PIX_PER_POINT=1.
// Expected scores and busy lengths are pushed to queues when a frame is driven.
// They are popped and compared once the update loop finishes.
module tb_score_keeper;

`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;

    logic        frame8, ref8, go8, ng8;
    logic [7:0]  disp8;
    logic [23:0] score8, hi8;
    logic        nh8, busy8, over8;

    logic        frame1, ref1, go1, ng1;
    logic [7:0]  disp1;
    logic [23:0] score1, hi1;
    logic        nh1, busy1, over1;

    int errors = 0;
    int checks = 0;

    int          m8_res, m8_score, m1_res, m1_score;
    logic [23:0] q8[$];
    int          cq8[$];
    logic [23:0] q1[$];
    int          cq1[$];

    score_keeper #(.PIX_PER_POINT(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame8), .refresh_en(ref8),
        .displacement(disp8), .game_over(go8), .new_game(ng8),
        .score_bcd(score8), .hiscore_bcd(hi8), .new_high(nh8), .busy(busy8), .over(over8)
    );

    score_keeper #(.PIX_PER_POINT(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame1), .refresh_en(ref1),
        .displacement(disp1), .game_over(go1), .new_game(ng1),
        .score_bcd(score1), .hiscore_bcd(hi1), .new_high(nh1), .busy(busy1), .over(over1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = 24'd0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model8(input logic r, input int d);
        int cyc;
        cyc = 0;
        if (r) begin
            m8_res = m8_res + d;
            cyc = 1;
            while (m8_res >= 8) begin
                m8_res = m8_res - 8;
                if (m8_score < 999999) m8_score = m8_score + 1;
                cyc = cyc + 1;
            end
        end
        q8.push_back(to_bcd(m8_score));
        cq8.push_back(cyc);
    endtask

    task automatic model1(input int d);
        int cyc;
        m1_res = m1_res + d;
        cyc = 1;
        while (m1_res >= 1) begin
            m1_res = m1_res - 1;
            if (m1_score < 999999) m1_score = m1_score + 1;
            cyc = cyc + 1;
        end
        q1.push_back(to_bcd(m1_score));
        cq1.push_back(cyc);
    endtask

    task automatic tick8(input logic r, input logic [7:0] d);
        step();
        ref8 = r; disp8 = d; frame8 = 1'b1;
        step();
        frame8 = 1'b0;
    endtask

    task automatic tick1(input logic [7:0] d);
        step();
        ref1 = 1'b1; disp1 = d; frame1 = 1'b1;
        step();
        frame1 = 1'b0;
    endtask

    task automatic wait_idle8(output int n);
        n = 0;
        while (busy8 && n < 600) begin
            n = n + 1;
            step();
        end
    endtask

    task automatic wait_idle1(output int n);
        n = 0;
        while (busy1 && n < 600) begin
            n = n + 1;
            step();
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame8 = 1'b0; ref8 = 1'b0; disp8 = 8'd0; go8 = 1'b0; ng8 = 1'b0;
        frame1 = 1'b0; ref1 = 1'b0; disp1 = 8'd0; go1 = 1'b0; ng1 = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
        m8_res = 0; m8_score = 0; m1_res = 0; m1_score = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (score8 !== 24'h000000) begin errors++; $display("FAIL reset_score got %h expected %h", score8, 24'h000000); end
        checks++; if (hi8 !== 24'h000000) begin errors++; $display("FAIL reset_hiscore got %h expected %h", hi8, 24'h000000); end
        checks++; if ({nh8, busy8, over8} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {nh8, busy8, over8}); end
        checks++; if (dut8.residue_r !== 9'd0) begin errors++; $display("FAIL reset_residue got %0d expected 0", dut8.residue_r); end
    endtask

    task automatic test_basic();
        int n;
        logic [23:0] e;
        int ec;
        for (int i = 0; i < 3; i++) begin
            model8(1'b1, 20);
            tick8(1'b1, 8'd20);
            wait_idle8(n);
            e = q8.pop_front();
            ec = cq8.pop_front();
            checks++; if (n !== ec) begin errors++; $display("FAIL basic_busy_len[%0d] got %0d expected %0d", i, n, ec); end
            checks++; if (score8 !== e) begin errors++; $display("FAIL basic_score[%0d] got %h expected %h", i, score8, e); end
        end
        checks++; if (int'(dut8.residue_r) !== m8_res) begin errors++; $display("FAIL basic_residue got %0d expected %0d", dut8.residue_r, m8_res); end
    endtask

    task automatic test_scroll_disabled();
        int nb;
        logic [23:0] e;
        nb = 0;
        for (int i = 0; i < 2; i++) begin
            model8(1'b0, 50);
            tick8(1'b0, 8'd50);
            if (busy8) nb++;
            for (int k = 0; k < 4; k++) begin
                step();
                if (busy8) nb++;
            end
            e = q8.pop_front();
            void'(cq8.pop_front());
            checks++; if (score8 !== e) begin errors++; $display("FAIL disabled_score[%0d] got %h expected %h", i, score8, e); end
        end
        checks++; if (nb !== 0) begin errors++; $display("FAIL disabled_busy got %0d busy cycles expected 0", nb); end
    endtask

    task automatic test_carry_saturation();
        int n;
        logic [23:0] e;
        int ec;
        int dl[2];
        dl[0] = 99; dl[1] = 1;
        for (int i = 0; i < 2; i++) begin
            model1(dl[i]);
            tick1(8'(dl[i]));
            wait_idle1(n);
            e = q1.pop_front();
            ec = cq1.pop_front();
            checks++; if (n !== ec) begin errors++; $display("FAIL carry_busy_len[%0d] got %0d expected %0d", i, n, ec); end
            checks++; if (score1 !== e) begin errors++; $display("FAIL carry_score[%0d] got %h expected %h", i, score1, e); end
        end
        force dut1.score_r = 24'h999990;
        step();
        release dut1.score_r;
        m1_score = 999990;
        step();
        checks++; if (score1 !== to_bcd(m1_score)) begin errors++; $display("FAIL sat_preload got %h expected %h", score1, to_bcd(m1_score)); end
        model1(20);
        tick1(8'd20);
        wait_idle1(n);
        e = q1.pop_front();
        ec = cq1.pop_front();
        checks++; if (n !== ec) begin errors++; $display("FAIL sat_busy_len got %0d expected %0d", n, ec); end
        checks++; if (score1 !== e) begin errors++; $display("FAIL sat_score got %h expected %h", score1, e); end
    endtask

    task automatic test_game_over_mid_update();
        logic [23:0] e;
        logic [23:0] eh;
        do_reset();
        // Four update steps complete before game_over is sampled on the 5th update cycle.
        q8.push_back(to_bcd(4));
        eh = HI_EN ? to_bcd(4) : 24'h000000;
        tick8(1'b1, 8'd200);
        for (int k = 0; k < 4; k++) step();
        go8 = 1'b1;
        step();
        e = q8.pop_front();
        checks++; if (score8 !== e) begin errors++; $display("FAIL go_score got %h expected %h", score8, e); end
        checks++; if ({over8, busy8} !== 2'b10) begin errors++; $display("FAIL go_state got over,busy=%b expected 10", {over8, busy8}); end
        checks++; if (hi8 !== eh) begin errors++; $display("FAIL go_hiscore got %h expected %h", hi8, eh); end
        checks++; if (nh8 !== HI_EN) begin errors++; $display("FAIL go_new_high got %b expected %b", nh8, HI_EN); end
        checks++; if (dut8.residue_r !== 9'd0) begin errors++; $display("FAIL go_residue got %0d expected 0", dut8.residue_r); end
        tick8(1'b1, 8'd50);
        tick8(1'b1, 8'd50);
        step();
        checks++; if (score8 !== e) begin errors++; $display("FAIL over_ignores_tick got %h expected %h", score8, e); end
        checks++; if ({over8, busy8} !== 2'b10) begin errors++; $display("FAIL over_hold got over,busy=%b expected 10", {over8, busy8}); end
    endtask

    task automatic test_restart_second_game();
        int n;
        logic [23:0] e;
        int ec;
        logic [23:0] eh;
        eh = HI_EN ? to_bcd(4) : 24'h000000;
        go8 = 1'b0; ng8 = 1'b1;
        step();
        ng8 = 1'b0;
        m8_res = 0; m8_score = 0;
        checks++; if (score8 !== 24'h000000) begin errors++; $display("FAIL restart_score got %h expected 000000", score8); end
        checks++; if ({nh8, over8} !== 2'b00) begin errors++; $display("FAIL restart_flags got new_high,over=%b expected 00", {nh8, over8}); end
        checks++; if (hi8 !== eh) begin errors++; $display("FAIL restart_hiscore got %h expected %h", hi8, eh); end
        model8(1'b1, 16);
        tick8(1'b1, 8'd16);
        wait_idle8(n);
        e = q8.pop_front();
        ec = cq8.pop_front();
        checks++; if (n !== ec) begin errors++; $display("FAIL game2_busy_len got %0d expected %0d", n, ec); end
        checks++; if (score8 !== e) begin errors++; $display("FAIL game2_score got %h expected %h", score8, e); end
        go8 = 1'b1;
        step();
        checks++; if (hi8 !== eh) begin errors++; $display("FAIL game2_hiscore got %h expected %h", hi8, eh); end
        checks++; if ({nh8, over8} !== 2'b01) begin errors++; $display("FAIL game2_flags got new_high,over=%b expected 01", {nh8, over8}); end
        ng8 = 1'b1;
        step();
        step();
        ng8 = 1'b0;
        checks++; if (over8 !== 1'b1) begin errors++; $display("FAIL both_high_over got %b expected 1", over8); end
        checks++; if (score8 !== e) begin errors++; $display("FAIL both_high_score got %h expected %h", score8, e); end
    endtask

    task automatic test_reset_in_over();
        int n;
        logic [23:0] e;
        int ec;
        Reset_n = 1'b0;
        go8 = 1'b0;
        step();
        Reset_n = 1'b1;
        m8_res = 0; m8_score = 0;
        checks++; if ({score8, hi8} !== 48'd0) begin errors++; $display("FAIL rst_over_values got %h/%h expected 000000/000000", score8, hi8); end
        checks++; if ({nh8, busy8, over8} !== 3'b000) begin errors++; $display("FAIL rst_over_flags got %b expected 000", {nh8, busy8, over8}); end
        model8(1'b1, 8);
        tick8(1'b1, 8'd8);
        wait_idle8(n);
        e = q8.pop_front();
        ec = cq8.pop_front();
        checks++; if (n !== ec) begin errors++; $display("FAIL rst_play_busy_len got %0d expected %0d", n, ec); end
        checks++; if (score8 !== e) begin errors++; $display("FAIL rst_play_score got %h expected %h", score8, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scroll_disabled();
        test_carry_saturation();
        test_game_over_mid_update();
        test_restart_second_game();
        test_reset_in_over();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
